// File: rtl/usb_uart_pkg.sv
// Shared types and default sizing for the USB CDC byte bridge.
// Optional level outputs are enabled by defining USB_UART_BRIDGE_LEVELS_EN.
package usb_uart_pkg;

   typedef logic [7:0] byte_t;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } bridge_state_t;

   localparam int DEF_DEPTH        = 64;
   localparam int DEF_MAX_PKT      = 32;
   localparam int DEF_FLUSH_CYCLES = 48000;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with extra-MSB pointers, registered occupancy count
// and a combinational head read. Pushes at full and pops at empty are ignored.
module byte_fifo
   import usb_uart_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  byte_t                  din,
   output byte_t                  head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   byte_t       mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        do_push;
   logic        do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr[AW-1:0]];

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= {(AW+1){1'b0}};
         rd_ptr <= {(AW+1){1'b0}};
         count  <= {(AW+1){1'b0}};
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count <= count + PTR_ONE;
            2'b01:   count <= count - PTR_ONE;
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents need no reset since empty masks them.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/usb_uart_bridge.sv
// Bridges the uart_we/uart_re client interface to CDC bulk endpoints, with an
// IN packetiser. Define USB_UART_BRIDGE_LEVELS_EN to expose rx_level/tx_level.
module usb_uart_bridge
   import usb_uart_pkg::*;
#(
   parameter int DEPTH        = DEF_DEPTH,
   parameter int MAX_PKT      = DEF_MAX_PKT,
   parameter int FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
   input  logic       clk_48mhz,
   input  logic       reset,
   input  logic       uart_we,
   input  logic       uart_re,
   input  byte_t      uart_di,
   output byte_t      uart_do,
   output logic       uart_wait,
   input  logic       out_valid,
   input  byte_t      out_data,
   output logic       out_ready,
   output logic       in_valid,
   output byte_t      in_data,
   output logic       in_last,
   input  logic       in_ready
`ifdef USB_UART_BRIDGE_LEVELS_EN
   ,
   output logic [$clog2(DEPTH):0] rx_level,
   output logic [$clog2(DEPTH):0] tx_level
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int IW = $clog2(FLUSH_CYCLES);
   localparam logic [CW-1:0] PKT_MAX   = CW'(MAX_PKT);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] CNT_TWO   = CW'(2);
   localparam logic [IW-1:0] IDLE_LAST = IW'(FLUSH_CYCLES - 1);
   localparam logic [IW-1:0] IDLE_MAX  = {IW{1'b1}};
   localparam logic [IW-1:0] IDLE_ONE  = IW'(1);

   bridge_state_t state;
   logic [CW-1:0] remaining;
   logic [IW-1:0] idle_cnt;
   logic [CW-1:0] rx_count;
   logic [CW-1:0] tx_count;
   logic          rx_full, rx_empty, tx_full, tx_empty;
   byte_t         rx_head;
   logic          wr_acc, rd_acc, tx_pop;

   // A stall on either direction holds off both requests.
   assign uart_wait = (uart_we && tx_full) || (uart_re && rx_empty);
   assign wr_acc    = uart_we && !uart_wait;
   assign rd_acc    = uart_re && !uart_wait;
   assign out_ready = !rx_full;
   assign tx_pop    = in_valid && in_ready;

   byte_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
      .clk   (clk_48mhz),
      .reset (reset),
      .push  (out_valid),
      .pop   (rd_acc),
      .din   (out_data),
      .head  (rx_head),
      .full  (rx_full),
      .empty (rx_empty),
      .count (rx_count)
   );

   byte_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
      .clk   (clk_48mhz),
      .reset (reset),
      .push  (wr_acc),
      .pop   (tx_pop),
      .din   (uart_di),
      .head  (in_data),
      .full  (tx_full),
      .empty (tx_empty),
      .count (tx_count)
   );

`ifdef USB_UART_BRIDGE_LEVELS_EN
   assign rx_level = rx_count;
   assign tx_level = tx_count;
`else
   logic unused_rx_count;
   assign unused_rx_count = ^rx_count;
`endif

   // Read-data register plus the IN packetiser FSM.
   always_ff @(posedge clk_48mhz) begin
      if (reset) begin
         state     <= IDLE;
         remaining <= {CW{1'b0}};
         idle_cnt  <= {IW{1'b0}};
         in_valid  <= 1'b0;
         in_last   <= 1'b0;
         uart_do   <= 8'h00;
      end else begin
         if (rd_acc) uart_do <= rx_head;
         case (state)
            IDLE: begin
               if (tx_count >= PKT_MAX) begin
                  state     <= SEND;
                  remaining <= PKT_MAX;
                  in_valid  <= 1'b1;
                  in_last   <= (PKT_MAX == CNT_ONE);
                  idle_cnt  <= {IW{1'b0}};
               end else if (!tx_empty && idle_cnt == IDLE_LAST) begin
                  // Short packet: tx_count is already below MAX_PKT here.
                  state     <= SEND;
                  remaining <= tx_count;
                  in_valid  <= 1'b1;
                  in_last   <= (tx_count == CNT_ONE);
                  idle_cnt  <= {IW{1'b0}};
               end else if (tx_empty || wr_acc) begin
                  idle_cnt  <= {IW{1'b0}};
               end else if (idle_cnt != IDLE_MAX) begin
                  idle_cnt  <= idle_cnt + IDLE_ONE;
               end
            end
            SEND: begin
               if (tx_pop) begin
                  if (in_last) begin
                     state    <= IDLE;
                     in_valid <= 1'b0;
                     in_last  <= 1'b0;
                  end else begin
                     remaining <= remaining - CNT_ONE;
                     in_last   <= (remaining == CNT_TWO);
                  end
               end
            end
            default: begin
               state    <= IDLE;
               in_valid <= 1'b0;
               in_last  <= 1'b0;
            end
         endcase
      end
   end

endmodule
